// File: rtl/uart_reg_bridge.sv
// Serial command bridge: parses SYNC/CMD/ADDR/DATA/CHK frames from the UART RX FIFO and drives
// register strobes and ACK/NAK/read responses. Optional inter-byte timeout: UART_REG_BRIDGE_TIMEOUT_EN.
module uart_reg_bridge #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [7:0]  ACK_BYTE       = 8'h4B,
  parameter logic [7:0]  NAK_BYTE       = 8'h45,
  parameter logic [7:0]  RD_HDR         = 8'h5A,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_fifo_empty,
  input  logic [7:0] r_data,
  output logic       r_uart,
  input  logic       tx_fifo_full,
  output logic [7:0] w_data,
  output logic       w_uart,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic [7:0] frame_cnt,
  output logic [7:0] err_cnt
);

  localparam logic [3:0] S_HUNT       = 4'd0;
  localparam logic [3:0] S_GET_CMD    = 4'd1;
  localparam logic [3:0] S_GET_ADDR   = 4'd2;
  localparam logic [3:0] S_GET_DATA   = 4'd3;
  localparam logic [3:0] S_GET_CHK    = 4'd4;
  localparam logic [3:0] S_EXEC       = 4'd5;
  localparam logic [3:0] S_RD_CAP     = 4'd6;
  localparam logic [3:0] S_SEND_FIRST = 4'd7;
  localparam logic [3:0] S_SEND_LAST  = 4'd8;

  localparam logic [1:0] K_NAK = 2'd0;
  localparam logic [1:0] K_WR  = 2'd1;
  localparam logic [1:0] K_RD  = 2'd2;

  logic [3:0] state_q, state_d;
  logic [7:0] cmd_q, cmd_d, addr_q, addr_d, data_q, data_d;
  logic [1:0] kind_q, kind_d;
  logic [7:0] reg_addr_q, reg_addr_d, reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d, reg_re_q, reg_re_d;
  logic [7:0] tx_byte_q, tx_byte_d, w_data_q, w_data_d;
  logic       w_uart_q, w_uart_d;
  logic [7:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
  logic       pop;
  logic [7:0] chk_calc;
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
  logic [23:0] to_q, to_d;
`endif

  // States 0..4 are the receive states; popping is purely combinational from the FIFO flag.
  assign pop      = (state_q <= S_GET_CHK) && !rx_fifo_empty && !reset;
  assign chk_calc = cmd_q ^ addr_q ^ data_q;

  assign r_uart    = pop;
  assign w_data    = w_data_q;
  assign w_uart    = w_uart_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    kind_d      = kind_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    tx_byte_d   = tx_byte_q;
    w_data_d    = w_data_q;
    w_uart_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    to_d        = '0;
`endif
    case (state_q)
      S_HUNT:     if (pop && r_data == SYNC_BYTE) state_d = S_GET_CMD;
      S_GET_CMD:  if (pop) begin cmd_d  = r_data; state_d = S_GET_ADDR; end
      S_GET_ADDR: if (pop) begin addr_d = r_data; state_d = S_GET_DATA; end
      S_GET_DATA: if (pop) begin data_d = r_data; state_d = S_GET_CHK;  end
      S_GET_CHK: if (pop) begin
        state_d = S_EXEC;
        if (chk_calc == r_data && cmd_q == 8'h01) begin
          kind_d      = K_WR;
          reg_we_d    = 1'b1;
          reg_addr_d  = addr_q;
          reg_wdata_d = data_q;
        end else if (chk_calc == r_data && cmd_q == 8'h02) begin
          kind_d     = K_RD;
          reg_re_d   = 1'b1;
          reg_addr_d = addr_q;
        end else begin
          kind_d = K_NAK;
        end
      end
      S_EXEC: begin
        if (kind_q == K_RD) begin
          state_d = S_RD_CAP;
        end else begin
          state_d = S_SEND_LAST;
          if (kind_q == K_WR) begin
            tx_byte_d   = ACK_BYTE;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            tx_byte_d = NAK_BYTE;
            err_cnt_d = err_cnt_q + 8'd1;
          end
          if (!tx_fifo_full) begin w_uart_d = 1'b1; w_data_d = tx_byte_d; end
        end
      end
      S_RD_CAP: begin
        tx_byte_d   = reg_rdata;
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = S_SEND_FIRST;
        if (!tx_fifo_full) begin w_uart_d = 1'b1; w_data_d = RD_HDR; end
      end
      // A high w_uart_q in a send state means that state's byte is leaving this cycle.
      S_SEND_FIRST: begin
        if (w_uart_q) begin
          state_d = S_SEND_LAST;
          if (!tx_fifo_full) begin w_uart_d = 1'b1; w_data_d = tx_byte_q; end
        end else if (!tx_fifo_full) begin
          w_uart_d = 1'b1;
          w_data_d = RD_HDR;
        end
      end
      S_SEND_LAST: begin
        if (w_uart_q) state_d = S_HUNT;
        else if (!tx_fifo_full) begin w_uart_d = 1'b1; w_data_d = tx_byte_q; end
      end
      default: state_d = S_HUNT;
    endcase
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    // Idle-wait counter for a partial frame; expiry drops the frame silently.
    if (state_q >= S_GET_CMD && state_q <= S_GET_CHK && rx_fifo_empty) begin
      if (to_q + 24'd1 == TIMEOUT_CYCLES) begin
        state_d   = S_HUNT;
        err_cnt_d = err_cnt_q + 8'd1;
      end else begin
        to_d = to_q + 24'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_HUNT;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      kind_q      <= K_NAK;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      tx_byte_q   <= '0;
      w_data_q    <= '0;
      w_uart_q    <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
      to_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      kind_q      <= kind_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      tx_byte_q   <= tx_byte_d;
      w_data_q    <= w_data_d;
      w_uart_q    <= w_uart_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
      to_q        <= to_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench for uart_reg_bridge: FIFO models, a frame-level reference model and a monitor.
module tb_uart_reg_bridge;
  logic       clk = 1'b0;
  logic       reset;
  logic       rx_fifo_empty, r_uart, tx_fifo_full, w_uart, reg_we, reg_re;
  logic [7:0] r_data, w_data, reg_addr, reg_wdata, reg_rdata, frame_cnt, err_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_reg_bridge #(.TIMEOUT_CYCLES(24'd100)) dut (
    .clk(clk), .reset(reset), .rx_fifo_empty(rx_fifo_empty), .r_data(r_data), .r_uart(r_uart),
    .tx_fifo_full(tx_fifo_full), .w_data(w_data), .w_uart(w_uart), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  logic [7:0]  rxq[$];
  logic [7:0]  exp_tx[$];
  logic [16:0] exp_reg[$];      // {is_write, addr, data}
  logic [7:0]  bank[256];       // register bank behind the DUT
  logic [7:0]  mmem[256];       // reference model's view of the bank
  int          m_frames = 0;
  int          m_errs = 0;
  int          cyc = 0;
  int          last_pop = 0;
  logic        full_q = 1'b0;
  logic        rand_full = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  // RX FIFO pop side, register bank, and edge-time bookkeeping.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    full_q <= tx_fifo_full;
    if (r_uart && rxq.size() > 0) begin
      void'(rxq.pop_front());
      if (rxq.size() == 0) begin
        last_pop <= cyc;
        rx_fifo_empty <= 1'b1;
      end else begin
        r_data <= rxq[0];
      end
    end
    if (reg_we) bank[reg_addr] = reg_wdata;
    reg_rdata <= reg_re ? bank[reg_addr] : 8'($urandom);
  end

  always @(negedge clk) if (rand_full) tx_fifo_full = ($urandom_range(0, 3) == 0);

  // Monitor: every DUT output event is matched against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (w_uart) begin
        chk("push_while_full", 32'(full_q), 32'd0);
        if (exp_tx.size() == 0) fail("unexpected_push", 32'(w_data));
        else chk("tx_byte", 32'(w_data), 32'(exp_tx.pop_front()));
      end
      if (reg_we && reg_re) fail("we_and_re", 32'd3);
      if (reg_we) begin
        if (exp_reg.size() == 0) fail("unexpected_we", {reg_addr, reg_wdata});
        else chk("reg_write", {15'd0, 1'b1, reg_addr, reg_wdata}, 32'(exp_reg.pop_front()));
      end
      if (reg_re) begin
        if (exp_reg.size() == 0) fail("unexpected_re", 32'(reg_addr));
        else chk("reg_read", {15'd0, 1'b0, reg_addr, 8'h00}, 32'(exp_reg.pop_front()));
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    rxq.push_back(b);
    r_data = rxq[0];
    rx_fifo_empty = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d, input logic [7:0] k);
    if ((c ^ a ^ d) == k && c == 8'h01) begin
      exp_reg.push_back({1'b1, a, d});
      exp_tx.push_back(8'h4B);
      mmem[a] = d;
      m_frames++;
    end else if ((c ^ a ^ d) == k && c == 8'h02) begin
      exp_reg.push_back({1'b0, a, 8'h00});
      exp_tx.push_back(8'h5A);
      exp_tx.push_back(mmem[a]);
      m_frames++;
    end else begin
      exp_tx.push_back(8'h45);
      m_errs++;
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d, input logic [7:0] k,
                            input int gap);
    logic [7:0] fr[5];
    fr[0] = 8'hA5; fr[1] = c; fr[2] = a; fr[3] = d; fr[4] = k;
    model_frame(c, a, d, k);
    for (int i = 0; i < 5; i++) begin
      push_byte(fr[i]);
      repeat ($urandom_range(0, gap)) @(negedge clk);
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((rxq.size() != 0 || exp_tx.size() != 0 || exp_reg.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    if (n >= 3000) fail({tag, "_drain_timeout"}, 32'(exp_tx.size()));
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(8'(m_frames)));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(8'(m_errs)));
  endtask

  // Whole frame lands in the FIFO at once, so the last pop is the CHK byte.
  task automatic lat_frame(input string name, input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] k, input int lat, input logic two);
    int n;
    send_frame(c, a, d, k, 0);
    n = 0;
    while (!w_uart && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 32'(cyc - last_pop), 32'(lat));
    if (two) begin
      @(negedge clk);
      chk({name, "_second_push"}, 32'(w_uart), 32'd1);
    end
    drain(name);
  endtask

  logic [7:0] c, a, d, k, g;
  int t;

  initial begin
    reset = 1'b1;
    tx_fifo_full = 1'b0;
    rx_fifo_empty = 1'b1;
    r_data = 8'h00;
    for (int i = 0; i < 256; i++) begin
      bank[i] = 8'($urandom);
      mmem[i] = bank[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_w_uart", 32'(w_uart), 32'd0);
    chk("rst_reg_we", 32'(reg_we), 32'd0);
    chk("rst_reg_re", 32'(reg_re), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    lat_frame("write", 8'h01, 8'h10, 8'h3C, 8'h2D, 2, 1'b0);
    bank[8'h10] = 8'h77;
    mmem[8'h10] = 8'h77;
    lat_frame("read", 8'h02, 8'h10, 8'h00, 8'h12, 3, 1'b1);
    lat_frame("bad_chk", 8'h01, 8'h10, 8'h3C, 8'h00, 2, 1'b0);
    lat_frame("bad_cmd", 8'h07, 8'h00, 8'h00, 8'h07, 2, 1'b0);
    push_byte(8'h00);
    push_byte(8'hFF);
    lat_frame("garbage", 8'h01, 8'h20, 8'h01, 8'h20, 2, 1'b0);

    // Read response held off by a full TX FIFO.
    tx_fifo_full = 1'b1;
    send_frame(8'h02, 8'h10, 8'h00, 8'h12, 0);
    repeat (12) @(negedge clk);
    chk("full_hold_pending", 32'(exp_tx.size()), 32'd2);
    tx_fifo_full = 1'b0;
    drain("full_hold");

    // Reset after the ADDR byte: partial frame lost, counters restart.
    push_byte(8'hA5); push_byte(8'h01); push_byte(8'h10);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    push_byte(8'hA5);
    #1;
    chk("rst_mid_r_uart", 32'(r_uart), 32'd0);
    @(negedge clk);
    chk("rst_mid_w_uart", 32'(w_uart), 32'd0);
    chk("rst_mid_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_mid_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_mid_reg_addr", 32'(reg_addr), 32'd0);
    rxq.delete();
    rx_fifo_empty = 1'b1;
    m_frames = 0;
    m_errs = 0;
    reset = 1'b0;
    @(negedge clk);
    lat_frame("after_rst", 8'h01, 8'h33, 8'h44, 8'h76, 2, 1'b0);

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    push_byte(8'hA5);
    push_byte(8'h01);
    repeat (110) @(negedge clk);
    m_errs++;
    drain("timeout");
    send_frame(8'h01, 8'h05, 8'h06, 8'h02, 0);
    drain("after_timeout");
`endif

    // Randomized frames with garbage, byte gaps, overlap and TX back-pressure.
    rand_full = 1'b1;
    for (int i = 0; i < 40; i++) begin
      t = $urandom_range(0, 5);
      a = 8'($urandom_range(0, 15));
      d = ($urandom_range(0, 4) == 0) ? 8'hA5 : 8'($urandom);
      c = (t < 2) ? 8'h01 : (t < 4) ? 8'h02 : 8'($urandom_range(1, 2));
      if (t == 5) begin
        c = 8'($urandom);
        if (c == 8'h01 || c == 8'h02) c = 8'h07;
      end
      k = c ^ a ^ d;
      if (t == 4) k = k ^ 8'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0) begin
        for (int j = 0; j < 3; j++) begin
          g = 8'($urandom);
          if (g == 8'hA5) g = 8'h00;
          push_byte(g);
        end
      end
      send_frame(c, a, d, k, 2);
      if ($urandom_range(0, 2) == 0) drain("rnd");
    end
    drain("rnd_final");
    rand_full = 1'b0;
    @(negedge clk);
    tx_fifo_full = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
- Command-layer stage between the UART block's FIFOs and an internal register bank.
- Pops bytes from the UART receive FIFO and parses fixed 5-byte command frames.
- Issues register write or read strobes, then pushes response bytes into the UART transmit FIFO.
- Lets a host PC poke/peek HDMI2USB control registers over the serial link.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker
- ACK_BYTE, 8'h4B, write-success response
- NAK_BYTE, 8'h45, error response (bad checksum / unknown command)
- RD_HDR, 8'h5A, first byte of read response
- TIMEOUT_CYCLES, 24'd1000000, inter-byte timeout; used only with the optional feature

Ports:
- clk  in  1  system clock, same domain as the UART FIFO interfaces
- reset  in  1  asynchronous, active-high reset
- rx_fifo_empty  in  1  receive FIFO empty flag
- r_data  in  8  receive FIFO head byte (first-word fall-through; valid while not empty)
- r_uart  out  1  receive FIFO pop strobe
- tx_fifo_full  in  1  transmit FIFO full flag
- w_data  out  8  byte to push into transmit FIFO
- w_uart  out  1  transmit FIFO push strobe
- reg_addr  out  8  register address
- reg_wdata  out  8  register write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid exactly 1 cycle after reg_re
- frame_cnt  out  8  count of good frames executed; wraps 255->0
- err_cnt  out  8  count of NAKed frames; wraps 255->0

Behaviour:
- Frame format: SYNC, CMD, ADDR, DATA, CHK, with CHK = CMD ^ ADDR ^ DATA.
  - CMD 8'h01 = write; CMD 8'h02 = read (DATA ignored but still required).
- Reset (asynchronous, active-high): state=HUNT; all registered outputs and both counters = 0; r_uart=0, w_uart=0 while reset is high.
- r_uart is a combinational decode: 1 in HUNT/GET_CMD/GET_ADDR/GET_DATA/GET_CHK when rx_fifo_empty==0.
  - r_data is captured on the same edge.
  - Back-to-back pops on consecutive cycles are allowed.
- w_uart is a registered one-cycle pulse, asserted only when tx_fifo_full was 0 in the preceding cycle. w_data is held stable with it.
- States:
  - HUNT: pop and discard bytes until SYNC_BYTE is popped -> GET_CMD.
  - GET_CMD -> GET_ADDR -> GET_DATA -> GET_CHK: each advances on a pop. No other byte value is special; a SYNC value mid-frame is ordinary data.
  - GET_CHK pop (cycle N) -> EXEC at N+1.
  - EXEC:
    - Checksum bad or CMD not 01/02: err_cnt++, queue NAK_BYTE -> SEND_LAST.
    - Write: reg_we=1 for cycle N+1, with reg_addr/reg_wdata valid; frame_cnt++; queue ACK_BYTE -> SEND_LAST.
    - Read: reg_re=1 for cycle N+1; -> RD_CAP.
  - RD_CAP (N+2): latch reg_rdata; queue RD_HDR -> SEND_FIRST; frame_cnt++.
  - SEND_FIRST: when tx_fifo_full==0, push RD_HDR -> SEND_LAST with the latched read byte queued.
  - SEND_LAST: when tx_fifo_full==0, push queued byte -> HUNT.
  - While full, hold the state; no push and no byte loss.
- Minimum latency from CHK pop to response push: write/NAK = 2 cycles (push on N+2); read header = 3 cycles (push on N+3), data on N+4.
- No new bytes are popped during EXEC/RD_CAP/SEND_*. The receive FIFO absorbs the incoming bytes.
- reg_addr/reg_wdata hold their last values between frames.
- Reset mid-frame or mid-send: aborts immediately; the partial frame is lost and no response is sent.

Optional Feature:
- Macro: UART_REG_BRIDGE_TIMEOUT_EN.
- Defined:
  - A 24-bit counter clears on every pop and increments each cycle in GET_CMD..GET_CHK while rx_fifo_empty==1.
  - On reaching TIMEOUT_CYCLES: return to HUNT, err_cnt++, no response byte.
  - The counter is held at 0 in all other states.
- Not defined: no counter logic. A partial frame waits forever for its remaining bytes.

Test Plan:
- Write: A5 01 10 3C 2D -> reg_we pulse with addr 8'h10, data 8'h3C; push 4B on CHK-pop+2; frame_cnt=1.
- Read: A5 02 10 00 12, reg_rdata=8'h77 -> reg_re pulse; pushes 5A then 77; frame_cnt increments.
- Bad checksum: A5 01 10 3C 00 -> no reg_we; push 45; err_cnt=1. Unknown CMD: A5 07 00 00 07 -> push 45.
- Garbage before sync: 00 FF A5 01 20 01 20 -> garbage discarded; reg_we with addr 20, data 01; push 4B. Then hold tx_fifo_full=1 for 10 cycles during a read response -> no push while full; 5A,77 emitted in order after release.
- Reset asserted after ADDR byte, then a full write frame -> no response for the aborted frame; the new frame gives exactly one 4B; counters restarted from 0.
- With UART_REG_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=100: A5 01, then 100 idle cycles -> back to HUNT, err_cnt=1, no push; a following valid frame is ACKed.
